pipeline_sequencer: RTL

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
//
// Walks a face memory once per frame (faces 0..FACES-1), pushing a valid bit
// and face number down a shift pipeline that mirrors the datapath: one stage
// for the synchronous memory read plus PIPE_DEPTH datapath stages. A single
// global stall (output valid but not accepted) freezes the address counter,
// the FSM and every pipeline stage.
//
// Optional feature: define FRAME_LOOP_EN for continuous rendering (DONE
// returns straight to RUN). Without it, every frame needs a start request.
//
// Ports
//   clk          in   clock, all state changes on rising edge
//   reset        in   synchronous active-high reset
//   start        in   request one frame (only honoured in IDLE)
//   out_ready    in   downstream accepts the output face this cycle
//   mem_addr     out  face memory read address
//   stage_en     out  enable for all datapath stage registers (NOT stall)
//   out_valid    out  output face valid
//   out_face_num out  index of the face at the output
//   busy         out  high in any state other than IDLE
//   frame_done   out  one-cycle pulse when a frame completes
//   frame_count  out  completed frames, modulo 256
// ---------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter  int FACES      = 92,
  parameter  int PIPE_DEPTH = 2,
  localparam int AW         = $clog2(FACES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          out_ready,
  output logic [AW-1:0] mem_addr,
  output logic          stage_en,
  output logic          out_valid,
  output logic [AW-1:0] out_face_num,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    frame_count
);

  // Memory read stage plus the datapath stages.
  localparam int NST = PIPE_DEPTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_frame_count;
  logic          r_vld_p [NST];
  logic [AW-1:0] r_num_p [NST];

  logic          w_stall;
  logic          w_issue;
  logic          w_last_addr;
  logic          w_last_out;

  always_comb begin
    w_stall     = r_vld_p[NST-1] & ~out_ready;
    w_issue     = (r_state == S_RUN) & ~w_stall;
    w_last_addr = (r_mem_addr == AW'(FACES - 1));
    // The final face can only reach the output after the FSM is in DRAIN,
    // so its acceptance is what closes the frame.
    w_last_out  = r_vld_p[NST-1] & out_ready & (r_num_p[NST-1] == AW'(FACES - 1));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && w_last_addr) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_out) w_state_nxt = S_DONE;
`ifdef FRAME_LOOP_EN
      S_DONE:  w_state_nxt = S_RUN;
`else
      S_DONE:  w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mem_addr    <= '0;
      r_frame_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      // The address wraps to 0 after the last face, so IDLE/DONE -> RUN
      // always begins at face 0 without extra logic.
      if (w_issue) r_mem_addr <= w_last_addr ? '0 : r_mem_addr + AW'(1);
      if (r_state == S_DONE) r_frame_count <= r_frame_count + 8'd1;
    end
  end

  // Stage p0 is the memory read; p1..p(NST-1) are datapath stages. Bubbles
  // (vld=0) shift like real faces whenever the pipeline is not stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NST; i++) begin
        r_vld_p[i] <= 1'b0;
        r_num_p[i] <= '0;
      end
    end else if (!w_stall) begin
      r_vld_p[0] <= w_issue;
      r_num_p[0] <= r_mem_addr;
      for (int i = 1; i < NST; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        r_num_p[i] <= r_num_p[i-1];
      end
    end
  end

  assign mem_addr     = r_mem_addr;
  assign stage_en     = ~w_stall;
  assign out_valid    = r_vld_p[NST-1];
  assign out_face_num = r_num_p[NST-1];
  assign busy         = (r_state != S_IDLE);
  assign frame_done   = (r_state == S_DONE);
  assign frame_count  = r_frame_count;

endmodule
